// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low {a,b,c,d,e,f,g} patterns and the
// 5-bit digit codes, used by both the display driver and the scan capture.
package seg7_pkg;

    typedef logic [4:0] seg7_code_t;

    typedef enum logic [1:0] {
        AN_IDLE  = 2'd0,
        AN_LEGAL = 2'd1,
        AN_MULTI = 2'd2
    } an_class_t;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam seg7_code_t CODE_BLANK = 5'd16;
    localparam seg7_code_t CODE_UNK   = 5'd31;

    // Encoder side of the table; anything outside 0..9 is shown blank.
    function automatic logic [6:0] seg7_encode(input seg7_code_t code);
        logic [6:0] pat;
        case (code)
            5'd0:    pat = SEG_0;
            5'd1:    pat = SEG_1;
            5'd2:    pat = SEG_2;
            5'd3:    pat = SEG_3;
            5'd4:    pat = SEG_4;
            5'd5:    pat = SEG_5;
            5'd6:    pat = SEG_6;
            5'd7:    pat = SEG_7;
            5'd8:    pat = SEG_8;
            5'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational decode of an active-low segment pattern into a 5-bit digit code.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [4:0] code
);

    always_comb begin
        code = CODE_UNK;
        case (pattern)
            SEG_0:     code = 5'd0;
            SEG_1:     code = 5'd1;
            SEG_2:     code = 5'd2;
            SEG_3:     code = 5'd3;
            SEG_4:     code = 5'd4;
            SEG_5:     code = 5'd5;
            SEG_6:     code = 5'd6;
            SEG_7:     code = 5'd7;
            SEG_8:     code = 5'd8;
            SEG_9:     code = 5'd9;
            SEG_BLANK: code = CODE_BLANK;
            default:   code = CODE_UNK;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Monitors a multiplexed seven-segment display and rebuilds the four shown
// digit codes as coherent frames, with change detection and staleness timeout.
module seg_scan_capture
    import seg7_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic [3:0] an,
    output logic [4:0] dig0,
    output logic [4:0] dig1,
    output logic [4:0] dig2,
    output logic [4:0] dig3,
    output logic       frame_stb,
    output logic       change_stb,
    output logic       frame_valid,
    output logic       bad_an,
    output logic       stale
);

    localparam int               ST_W   = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [ST_W-1:0]  ST_MAX = ST_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [10:0]      IDLE_VEC = 11'h7FF;

    logic [6:0]       seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
    logic [3:0]       an_s1_q, an_s1_d, an_s2_q, an_s2_d;
    logic [10:0]      prev_q, prev_d;
    logic [ST_W-1:0]  stab_q, stab_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic [3:0]       seen_q, seen_d;
    logic [3:0][4:0]  stage_q, stage_d;
    logic [3:0][4:0]  dig_q, dig_d;
    logic             frame_stb_q, frame_stb_d;
    logic             change_stb_q, change_stb_d;
    logic             valid_q, valid_d;
    logic             bad_an_q, bad_an_d;
    logic             stale_q, stale_d;

    an_class_t        an_class;
    logic [1:0]       slot;
    logic [4:0]       code;
    logic             capture;
    logic             timeout;
    logic [3:0]       seen_with;
    logic [3:0][4:0]  stage_with;

    seg7_pattern_decode u_decode (
        .pattern (seg_s2_q),
        .code    (code)
    );

    always_comb begin
        an_class = AN_MULTI;
        slot     = 2'd0;
        case (an_s2_q)
            4'b1110: begin an_class = AN_LEGAL; slot = 2'd0; end
            4'b1101: begin an_class = AN_LEGAL; slot = 2'd1; end
            4'b1011: begin an_class = AN_LEGAL; slot = 2'd2; end
            4'b0111: begin an_class = AN_LEGAL; slot = 2'd3; end
            4'b1111: an_class = AN_IDLE;
            default: an_class = AN_MULTI;
        endcase
    end

    always_comb begin
        seg_s1_d = {a, b, c, d, e, f, g};
        an_s1_d  = an;
        seg_s2_d = seg_s1_q;
        an_s2_d  = an_s1_q;
        prev_d   = {an_s2_q, seg_s2_q};
        bad_an_d = (an_class == AN_MULTI);

        // Dwell counter saturates at ST_MAX so one steady dwell captures once.
        stab_d  = '0;
        capture = 1'b0;
        if (an_class == AN_LEGAL && {an_s2_q, seg_s2_q} == prev_q) begin
            if (stab_q != ST_MAX) begin
                stab_d  = stab_q + 1'b1;
                capture = (stab_q + 1'b1 == ST_MAX);
            end else begin
                stab_d = stab_q;
            end
        end

        stage_with = stage_q;
        seen_with  = seen_q;
        if (capture) begin
            stage_with[slot] = code;
            seen_with        = seen_q | (4'b0001 << slot);
        end
        stage_d = stage_with;

        timeout = 1'b0;
        if (capture) begin
            to_d = '0;
        end else if (to_q == TO_MAX) begin
            to_d    = '0;
            timeout = 1'b1;
        end else begin
            to_d = to_q + 1'b1;
        end

        dig_d        = dig_q;
        frame_stb_d  = 1'b0;
        change_stb_d = 1'b0;
        valid_d      = valid_q;
        stale_d      = stale_q;
        seen_d       = seen_with;
        if (capture && seen_with == 4'hF) begin
            dig_d        = stage_with;
            frame_stb_d  = 1'b1;
            change_stb_d = !valid_q || (stage_with != dig_q);
            valid_d      = 1'b1;
            stale_d      = 1'b0;
            seen_d       = '0;
        end else if (timeout) begin
            valid_d = 1'b0;
            stale_d = 1'b1;
            seen_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_s1_q     <= IDLE_VEC[6:0];
            seg_s2_q     <= IDLE_VEC[6:0];
            an_s1_q      <= IDLE_VEC[10:7];
            an_s2_q      <= IDLE_VEC[10:7];
            prev_q       <= IDLE_VEC;
            stab_q       <= '0;
            to_q         <= '0;
            seen_q       <= '0;
            dig_q        <= {4{CODE_BLANK}};
            frame_stb_q  <= 1'b0;
            change_stb_q <= 1'b0;
            valid_q      <= 1'b0;
            bad_an_q     <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            seg_s1_q     <= seg_s1_d;
            seg_s2_q     <= seg_s2_d;
            an_s1_q      <= an_s1_d;
            an_s2_q      <= an_s2_d;
            prev_q       <= prev_d;
            stab_q       <= stab_d;
            to_q         <= to_d;
            seen_q       <= seen_d;
            dig_q        <= dig_d;
            frame_stb_q  <= frame_stb_d;
            change_stb_q <= change_stb_d;
            valid_q      <= valid_d;
            bad_an_q     <= bad_an_d;
            stale_q      <= stale_d;
        end
    end

    // Staging only reaches the outputs once every slot is seen, so it needs no reset.
    always_ff @(posedge clk) begin
        stage_q <= stage_d;
    end

    assign dig0        = dig_q[0];
    assign dig1        = dig_q[1];
    assign dig2        = dig_q[2];
    assign dig3        = dig_q[3];
    assign frame_stb   = frame_stb_q;
    assign change_stb  = change_stb_q;
    assign frame_valid = valid_q;
    assign bad_an      = bad_an_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// Randomised and directed bench for seg_scan_capture with an in-bench reference model.
module tb_seg_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] an_in = 4'hF;
    logic [6:0] seg_in = 7'h7F;
    logic [4:0] dig0, dig1, dig2, dig3;
    logic       frame_stb, change_stb, frame_valid, bad_an, stale;

    int checks = 0;
    int failures = 0;
    int fcnt = 0;
    int ccnt = 0;
    int bcnt = 0;

    // Reference model state
    logic [10:0] pipe1, pipe2, last_val;
    int          run;
    int          m_stage [4];
    int          m_dig [4];
    bit   [3:0]  m_seen;
    int          m_to;
    bit          m_fstb, m_chg, m_valid, m_bad, m_stale;

    seg_scan_capture #(
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (21)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .a           (seg_in[6]),
        .b           (seg_in[5]),
        .c           (seg_in[4]),
        .d           (seg_in[3]),
        .e           (seg_in[2]),
        .f           (seg_in[1]),
        .g           (seg_in[0]),
        .an          (an_in),
        .dig0        (dig0),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .frame_stb   (frame_stb),
        .change_stb  (change_stb),
        .frame_valid (frame_valid),
        .bad_an      (bad_an),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input int dv);
        case (dv)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic int model_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (enc(i) == p) return i;
        if (p == 7'b1111111) return 16;
        return 31;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge of the reference behaviour: run lengths of identical synced samples.
    task automatic model_step();
        logic [10:0] cur;
        int zeros, s;
        bit changed;
        if (!rst) begin
            pipe1 = 11'h7FF; pipe2 = 11'h7FF; last_val = 11'h7FF; run = 0;
            for (int i = 0; i < 4; i++) m_dig[i] = 16;
            m_seen = '0; m_to = 0;
            m_fstb = 0; m_chg = 0; m_valid = 0; m_bad = 0; m_stale = 0;
            return;
        end
        cur = pipe2;
        if (cur == last_val) begin
            if (run < 1000) run++;
        end else begin
            run = 1;
        end
        last_val = cur;
        zeros = 0; s = 0;
        for (int i = 0; i < 4; i++)
            if (!cur[7+i]) begin zeros++; s = i; end
        m_bad = (zeros >= 2);
        m_fstb = 0; m_chg = 0;
        if (zeros == 1 && run == SETTLE) begin
            m_stage[s] = model_decode(cur[6:0]);
            m_seen[s] = 1'b1;
            m_to = 0;
            if (m_seen == 4'hF) begin
                changed = !m_valid;
                for (int i = 0; i < 4; i++)
                    if (m_stage[i] != m_dig[i]) changed = 1;
                for (int i = 0; i < 4; i++) m_dig[i] = m_stage[i];
                m_fstb = 1; m_chg = changed; m_valid = 1; m_stale = 0; m_seen = '0;
            end
        end else if (m_to == TIMEOUT - 1) begin
            m_valid = 0; m_stale = 1; m_seen = '0; m_to = 0;
        end else begin
            m_to++;
        end
        pipe2 = pipe1;
        pipe1 = {an_in, seg_in};
    endtask

    task automatic hold(input logic [3:0] a_v, input logic [6:0] s_v, input int n);
        an_in = a_v;
        seg_in = s_v;
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        hold(4'hF, 7'h7F, n);
    endtask

    task automatic scanp(input logic [6:0] p0, p1, p2, p3, input int dwell);
        hold(4'b1110, p0, dwell);
        hold(4'b1101, p1, dwell);
        hold(4'b1011, p2, dwell);
        hold(4'b0111, p3, dwell);
    endtask

    task automatic scan(input int d0, d1, d2, d3);
        scanp(enc(d0), enc(d1), enc(d2), enc(d3), 8);
        idle(3);
    endtask

    initial begin
        int f0, c0, b0;
        fork
            begin : cmp
                forever begin
                    @(posedge clk);
                    model_step();
                    #1;
                    chk("dig0", dig0, m_dig[0]);
                    chk("dig1", dig1, m_dig[1]);
                    chk("dig2", dig2, m_dig[2]);
                    chk("dig3", dig3, m_dig[3]);
                    chk("frame_stb", frame_stb, m_fstb);
                    chk("change_stb", change_stb, m_chg);
                    chk("frame_valid", frame_valid, m_valid);
                    chk("bad_an", bad_an, m_bad);
                    chk("stale", stale, m_stale);
                    if (frame_stb) fcnt++;
                    if (change_stb) ccnt++;
                    if (bad_an) bcnt++;
                end
            end
            begin : stim
                @(negedge clk);
                rst = 1'b0;
                idle(3);
                chk("reset_dig0", dig0, 16);
                chk("reset_valid", frame_valid, 0);
                rst = 1'b1;
                idle(2);

                f0 = fcnt; c0 = ccnt;
                scan(1, 2, 3, 4);
                chk("first_frame_stb_cnt", fcnt - f0, 1);
                chk("first_change_cnt", ccnt - c0, 1);
                chk("first_dig0", dig0, 1);
                chk("first_dig1", dig1, 2);
                chk("first_dig2", dig2, 3);
                chk("first_dig3", dig3, 4);
                chk("first_valid", frame_valid, 1);

                f0 = fcnt; c0 = ccnt;
                scan(1, 2, 3, 4);
                chk("repeat_frame_stb_cnt", fcnt - f0, 1);
                chk("repeat_change_cnt", ccnt - c0, 0);
                f0 = fcnt; c0 = ccnt;
                scan(1, 2, 7, 4);
                chk("dig2_change_cnt", ccnt - c0, 1);
                chk("dig2_new", dig2, 7);

                f0 = fcnt;
                for (int i = 0; i < 6; i++) hold(4'b1110, (i % 2) ? enc(5) : enc(3), 2);
                chk("glitch_no_frame", fcnt - f0, 0);
                hold(4'b1110, enc(3), 6);
                hold(4'b1101, enc(2), 8);
                hold(4'b1011, enc(7), 8);
                hold(4'b0111, enc(4), 8);
                idle(3);
                chk("glitch_frame_cnt", fcnt - f0, 1);
                chk("glitch_dig0", dig0, 3);

                f0 = fcnt; b0 = bcnt;
                hold(4'b1100, enc(8), 3);
                idle(4);
                chk("bad_an_cnt", bcnt - b0, 3);
                chk("bad_an_no_frame", fcnt - f0, 0);
                scan(5, 6, 7, 8);
                chk("after_bad_frame_cnt", fcnt - f0, 1);
                chk("after_bad_dig0", dig0, 5);

                idle(70);
                chk("timeout_valid", frame_valid, 0);
                chk("timeout_stale", stale, 1);
                chk("timeout_dig0_hold", dig0, 5);
                chk("timeout_dig3_hold", dig3, 8);
                f0 = fcnt; c0 = ccnt;
                scan(5, 6, 7, 8);
                chk("post_stale_frame_cnt", fcnt - f0, 1);
                chk("post_stale_change_cnt", ccnt - c0, 1);
                chk("post_stale_clear", stale, 0);

                scanp(enc(0), 7'b1110110, enc(9), 7'b1111111, 8);
                idle(3);
                chk("unknown_dig1", dig1, 31);
                chk("blank_dig3", dig3, 16);

                f0 = fcnt;
                hold(4'b1110, enc(4), 8);
                hold(4'b1101, enc(4), 8);
                rst = 1'b0;
                idle(2);
                rst = 1'b1;
                chk("midreset_dig0", dig0, 16);
                hold(4'b1011, enc(4), 8);
                hold(4'b0111, enc(4), 8);
                idle(3);
                chk("midreset_no_frame", fcnt - f0, 0);
                scan(9, 0, 1, 2);
                chk("midreset_full_frame", fcnt - f0, 1);
                chk("midreset_dig0_new", dig0, 9);

                for (int it = 0; it < 200; it++) begin
                    int r, n;
                    logic [3:0] av;
                    logic [6:0] sv;
                    r = $urandom_range(0, 19);
                    if (r < 15) av = ~(4'b0001 << $urandom_range(0, 3));
                    else if (r < 17) av = 4'hF;
                    else av = 4'($urandom_range(0, 15));
                    r = $urandom_range(0, 9);
                    if (r < 8) sv = enc($urandom_range(0, 9));
                    else if (r < 9) sv = 7'h7F;
                    else sv = 7'($urandom_range(0, 127));
                    n = $urandom_range(1, 10);
                    if ($urandom_range(0, 39) == 0) idle(70);
                    hold(av, sv, n);
                end
                idle(5);
            end
        join_any
        disable fork;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the multiplexed seven-segment display driver.
- Samples the active-low segment lines a..g and anode lines an[3:0] produced by the display scanner.
- Reconstructs the four 5-bit digit codes and presents them as a coherent frame with strobes.
- Serves as a self-check monitor in the tracker top level and as a scoreboard front end in benches.

Parameters:
SETTLE_CYCLES, 4, clk cycles {an,seg} must be unchanged before a digit is captured (min 2)
TIMEOUT_CYCLES, 2000000, clk cycles without any capture before the frame is declared stale
CNT_W, 21, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low
a,b,c,d,e,f,g  in  1 each  segment lines, active-low, asynchronous to clk
an  in  4  anode selects, active-low, an[0] = rightmost digit (dig0)
dig0,dig1,dig2,dig3  out  5 each  captured digit codes of last complete frame
frame_stb  out  1  one-cycle pulse when a new complete frame is loaded into dig0..dig3
change_stb  out  1  one-cycle pulse coincident with frame_stb when the frame differs from the previous one, or is the first frame after reset/stale
frame_valid  out  1  dig0..dig3 hold a frame that is not stale
bad_an  out  1  one-cycle pulse when two or more anodes are seen low simultaneously (post-sync)
stale  out  1  high while no frame has been captured within TIMEOUT_CYCLES

Behaviour:
- Reset (rst=0 at clk edge):
  - dig0..dig3 = 16 (blank).
  - frame_stb, change_stb, bad_an = 0; frame_valid = 0; stale = 0.
  - Seen mask, stability counter and timeout counter cleared.
- Input sync: two-flop synchronizer on all 11 inputs. All internal decisions use the synced value; input-to-decision latency is 2 cycles.
- Decode, pure function of the synced seg vector {a,b,c,d,e,f,g}:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0000100=9.
  - 1111111=16 (blank).
  - Any other pattern = 31 (unknown); still captured, not an error.
- Anode classification of synced an:
  - Exactly one bit low: legal; the index of the low bit is the digit slot.
  - 1111: idle; stability counter cleared, no capture.
  - Two or more bits low: bad_an pulses for one cycle per cycle of occurrence; stability counter cleared, no capture.
- Stability/capture:
  - The stability counter increments while the synced {an,seg} equals the previous cycle's value and an is legal; otherwise it resets to 0.
  - On the cycle the counter reaches SETTLE_CYCLES-1, the decoded code is written into staging[slot] and seen[slot] is set. The counter then saturates; at most one capture per dwell.
  - Recapture of an already-seen slot before the frame completes overwrites staging; seen is unchanged.
  - Every capture reloads the timeout counter to 0.
- Frame completion:
  - On the cycle where a capture makes seen == 1111, staging (including this capture) is copied to dig0..dig3 on the next edge.
  - frame_stb=1 for that one cycle, frame_valid=1, stale=0, seen cleared.
  - change_stb=1 in the same cycle if any digit differs from the old dig values, or if frame_valid was 0 before the update.
- Timeout:
  - The timeout counter increments every cycle without a capture.
  - On reaching TIMEOUT_CYCLES-1: frame_valid=0, stale=1, seen cleared. dig outputs hold their last values.
  - stale clears only on the next frame_stb.
  - If a capture and the timeout terminal count occur in the same cycle, the capture wins and no stale is asserted.
- Reset mid-frame discards partial staging; the next frame requires all four slots afresh.

Decomposition:
- Shared package seg7_pkg holds:
  - the ten active-low digit patterns and SEG_BLANK;
  - code constants CODE_BLANK=16, CODE_UNK=31;
  - the 5-bit code type.
- The display driver uses the same constants so encoder and decoder cannot drift.
- One combinational sub-module, seg7_pattern_decode (7-bit pattern in, 5-bit code out).
- Sync, stability, staging, timeout and frame logic stay in seg_scan_capture.

Test Plan:
- Scan 1,2,3,4 on an[0..3], 8 cycles per digit -> after the 4th capture, one frame_stb and one change_stb; dig0=1, dig1=2, dig2=3, dig3=4; frame_valid=1.
- Repeat the identical scan -> frame_stb each frame, change_stb=0; then change dig2 to 7 -> change_stb=1, dig2=7.
- Glitch: hold an=1110 with seg toggling every 2 cycles (SETTLE=4) -> no capture, no frame_stb; then hold 0000110 for 6 cycles -> staging[0]=3.
- Drive an=1100 for 3 cycles -> bad_an high 3 cycles (after 2-cycle sync); no capture; a subsequent legal scan completes normally.
- TIMEOUT_CYCLES=64: complete a frame, then hold an=1111 for 64 cycles -> frame_valid=0, stale=1, dig unchanged; next full scan -> frame_stb, change_stb=1, stale=0.
- Pattern 1110110 on slot 1 -> dig1=31; blank 1111111 on slot 3 -> dig3=16; assert rst=0 after 2 of 4 slots captured -> no frame until all 4 slots are rescanned.
